// File: rtl/barrido_pkg.sv
// barrido_pkg: shared FSM encoding, segment constants and glyph table
// for the multiplexed 7-segment scan driver.
package barrido_pkg;

    typedef enum logic {BLK, SHOW} state_e;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}; codes 10-15 render as a dash.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/barrido_display_dec7seg.sv
// dec7seg: combinational BCD to active-low 7-segment decoder with blanking.
module dec7seg
    import barrido_pkg::*;
(
    input  logic [3:0] val,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_OFF : GLYPH[val];

endmodule

// File: rtl/barrido_display.sv
// barrido_display: multiplexed N-digit 7-segment driver with prescaler tick,
// double-buffered BCD, anti-ghosting blank interval and select-fault detection.
module barrido_display
    import barrido_pkg::*;
#(
    parameter int N     = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 4,
    parameter int LZ    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [4*N-1:0] bcd,
    input  logic [N-1:0]   dp,
    input  logic [N-1:0]   sel,
    output logic           tick,
    output logic [N-1:0]   an,
    output logic [6:0]     seg,
    output logic           dp_n,
    output logic           err
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLANK - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tick_q, tick_d;
    state_e         state_q, state_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic [4*N-1:0] shadow_bcd_q, shadow_bcd_d, disp_bcd_q, disp_bcd_d;
    logic [N-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic [N-1:0]   an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_n_q, dp_n_d;
    logic           err_q, err_d;

    logic [3:0]     dig;
    logic           dp_sel, blank_lz, upper_zero, onehot, show;
    logic [6:0]     dec_seg;

    // Digit selection and leading-zero detection, scanning from the top digit down.
    always_comb begin
        dig        = '0;
        dp_sel     = 1'b0;
        blank_lz   = 1'b0;
        upper_zero = 1'b1;
        onehot     = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        for (int i = N - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_bcd_q[4*i +: 4] == 4'd0);
            if (sel[i]) begin
                dig      = disp_bcd_q[4*i +: 4];
                dp_sel   = disp_dp_q[i];
                blank_lz = (LZ != 0) && (i > 0) && upper_zero;
            end
        end
    end

    dec7seg u_dec (
        .val   (dig),
        .blank (blank_lz),
        .seg   (dec_seg)
    );

    always_comb begin
        cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        tick_d       = (cnt_d == CNT_MAX);
        shadow_bcd_d = load ? bcd : shadow_bcd_q;
        shadow_dp_d  = load ? dp : shadow_dp_q;
        // shadow_*_d already carries a same-cycle load, giving the bypass for free.
        disp_bcd_d   = tick_q ? shadow_bcd_d : disp_bcd_q;
        disp_dp_d    = tick_q ? shadow_dp_d : disp_dp_q;
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        if (tick_q) begin
            state_d = BLK;
            bcnt_d  = '0;
        end else if (state_q == BLK) begin
            state_d = (bcnt_q == BCNT_MAX) ? SHOW : BLK;
            bcnt_d  = (bcnt_q == BCNT_MAX) ? '0 : bcnt_q + 1'b1;
        end
        show   = (state_q == SHOW) && onehot;
        an_d   = show ? ~sel : '1;
        seg_d  = show ? dec_seg : SEG_OFF;
        dp_n_d = show ? ~dp_sel : 1'b1;
        err_d  = err_q | ((state_q == SHOW) && !onehot);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            state_q      <= BLK;
            bcnt_q       <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_n_q       <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_dp_q    <= disp_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            err_q        <= err_d;
        end
    end

    assign tick = tick_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dp_n_q;
    assign err  = err_q;

endmodule

// File: tb/tb_barrido_display.sv
// tb_barrido_display: randomized and directed checks of the scan driver against
// a slot-arithmetic reference model, with a one-hot ring supplying sel.
module tb_barrido_display;

    localparam int N = 4, DIV = 8, BLANK = 2, LZ = 1;

    logic clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [15:0] bcd = '0;
    logic [3:0]  dp = '0, sel, ring_q = 4'b0001, force_sel = '0;
    logic        force_en = 1'b0;
    logic        tick, dp_n, err;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_chk = 0, n_fail = 0;

    int t = 0;
    logic [15:0] sh_b = '0, ds_b = '0, pv_b = '0;
    logic [3:0]  sh_d = '0, ds_d = '0, pv_d = '0;

    always #5 clk = ~clk;

    barrido_display #(.N(N), .DIV(DIV), .BLANK(BLANK), .LZ(LZ)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd(bcd), .dp(dp), .sel(sel),
        .tick(tick), .an(an), .seg(seg), .dp_n(dp_n), .err(err)
    );

    always @(posedge clk or posedge rst)
        if (rst) ring_q <= 4'b0001;
        else if (tick) ring_q <= {ring_q[2:0], ring_q[3]};

    assign sel = force_en ? force_sel : ring_q;

    // Reference: slot m spans edges m*DIV .. m*DIV+DIV-1; disp latches at each slot start.
    always @(posedge clk or posedge rst)
        if (rst) begin
            t <= 0; sh_b <= '0; sh_d <= '0; ds_b <= '0; ds_d <= '0; pv_b <= '0; pv_d <= '0;
        end else begin
            if (t % DIV == DIV - 1) begin
                pv_b <= ds_b; pv_d <= ds_d;
                ds_b <= load ? bcd : sh_b;
                ds_d <= load ? dp : sh_d;
            end
            if (load) begin sh_b <= bcd; sh_d <= dp; end
            t <= t + 1;
        end

    function automatic logic [6:0] gl(input logic [3:0] v);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (v > 4'd9) ? 7'h3F : tbl[v];
    endfunction

    function automatic logic [11:0] exp_out();
        int m, r, i;
        logic [15:0] b;
        logic [3:0] d;
        logic [6:0] s;
        m = t / DIV;
        r = t % DIV;
        if (r <= BLANK && !(r == 0 && m > 0)) return {4'hF, 7'h7F, 1'b1};
        if (r == 0) begin m = m - 1; b = pv_b; d = pv_d; end
        else begin b = ds_b; d = ds_d; end
        i = m % N;
        s = (i > 0 && (b >> (4 * i)) == 16'd0) ? 7'h7F : gl(b[4*i +: 4]);
        return {~(4'b0001 << i), s, ~d[i]};
    endfunction

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1;
        #12;
        n_chk++;
        if ({an, seg, dp_n, tick, err} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state an=%b seg=%h dp_n=%b tick=%b err=%b expected 1111/7f/1/0/0", an, seg, dp_n, tick, err);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_out();
            n_chk++;
            if ({an, seg, dp_n} !== e) begin
                n_fail++;
                $display("FAIL reset_release t=%0d an=%b seg=%h dp_n=%b expected an=%b seg=%h dp_n=%b", t, an, seg, dp_n, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_tick();
        logic prev = 1'b0;
        for (int k = 0; k < 5 * DIV; k++) begin
            @(negedge clk);
            n_chk++;
            if (tick !== (t % DIV == DIV - 1) || (prev && tick)) begin
                n_fail++;
                $display("FAIL tick_period t=%0d tick=%b prev=%b expected %b", t, tick, prev, (t % DIV == DIV - 1));
            end
            prev = tick;
        end
    endtask

    task automatic test_scan();
        logic [11:0] e;
        logic [3:0] seen = '0;
        logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] sg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        load = 1'b1; bcd = 16'h1234; dp = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 7 * DIV; k++) begin
            @(negedge clk);
            e = exp_out();
            n_chk++;
            if ({an, seg, dp_n} !== e) begin
                n_fail++;
                $display("FAIL scan t=%0d an=%b seg=%h dp_n=%b expected an=%b seg=%h dp_n=%b", t, an, seg, dp_n, e[11:8], e[7:1], e[0]);
            end
            if (k >= 2 * DIV)
                for (int j = 0; j < 4; j++)
                    if (an === pat[j]) begin
                        seen[j] = 1'b1;
                        n_chk++;
                        if (seg !== sg[j]) begin
                            n_fail++;
                            $display("FAIL scan_glyph an=%b seg=%h expected %h", an, seg, sg[j]);
                        end
                    end
        end
        n_chk++;
        if (seen !== 4'hF) begin
            n_fail++;
            $display("FAIL scan_cover seen=%b expected 1111", seen);
        end
    endtask

    task automatic test_lz();
        logic [11:0] e;
        logic [15:0] vals [2] = '{16'h0050, 16'h000A};
        for (int v = 0; v < 2; v++) begin
            load = 1'b1; bcd = vals[v]; dp = 4'b0100;
            @(negedge clk);
            load = 1'b0;
            for (int k = 0; k < 6 * DIV; k++) begin
                @(negedge clk);
                e = exp_out();
                n_chk++;
                if ({an, seg, dp_n} !== e) begin
                    n_fail++;
                    $display("FAIL lz t=%0d an=%b seg=%h dp_n=%b expected an=%b seg=%h dp_n=%b", t, an, seg, dp_n, e[11:8], e[7:1], e[0]);
                end
                if (k >= 2 * DIV && an !== 4'hF) begin
                    n_chk++;
                    if (v == 0 && ((an === 4'b0111 && seg !== 7'h7F) || (an === 4'b1011 && (seg !== 7'h7F || dp_n !== 1'b0))
                        || (an === 4'b1101 && seg !== 7'h12) || (an === 4'b1110 && seg !== 7'h40))) begin
                        n_fail++;
                        $display("FAIL lz_0050 an=%b seg=%h dp_n=%b", an, seg, dp_n);
                    end else if (v == 1 && an === 4'b1110 && seg !== 7'h3F) begin
                        n_fail++;
                        $display("FAIL lz_dash an=%b seg=%h expected 3f", an, seg);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] e;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0, w = $urandom_range(1, 3 * DIV); k < w; k++) begin
                @(negedge clk);
                e = exp_out();
                n_chk++;
                if ({an, seg, dp_n} !== e) begin
                    n_fail++;
                    $display("FAIL random t=%0d an=%b seg=%h dp_n=%b expected an=%b seg=%h dp_n=%b", t, an, seg, dp_n, e[11:8], e[7:1], e[0]);
                end
                load = 1'b0;
            end
            load = 1'b1;
            bcd = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            dp = 4'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_collision();
        logic [11:0] e;
        logic found = 1'b0;
        for (int k = 0; k < 3 * DIV && !found; k++) begin
            @(negedge clk);
            found = (t % DIV == DIV - 1);
        end
        n_chk++;
        if (!found || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_wait found=%b tick=%b expected 1", found, tick);
        end
        load = 1'b1; bcd = 16'h9999; dp = 4'b0000;
        for (int k = 0; k < 3 * DIV; k++) begin
            @(negedge clk);
            load = 1'b0;
            e = exp_out();
            n_chk++;
            if ({an, seg, dp_n} !== e) begin
                n_fail++;
                $display("FAIL collision t=%0d an=%b seg=%h dp_n=%b expected an=%b seg=%h dp_n=%b", t, an, seg, dp_n, e[11:8], e[7:1], e[0]);
            end
            if (k < DIV && t % DIV > BLANK) begin
                n_chk++;
                if (seg !== 7'h10) begin
                    n_fail++;
                    $display("FAIL collision_nine k=%0d seg=%h expected 10", k, seg);
                end
            end
            if (k == 4) begin load = 1'b1; bcd = 16'h0000; end
        end
    endtask

    task automatic test_sel_fault();
        logic [11:0] e;
        logic found = 1'b0;
        for (int k = 0; k < 3 * DIV && !found; k++) begin
            @(negedge clk);
            found = (t % DIV == BLANK + 1);
        end
        force_en = 1'b1; force_sel = 4'b0011;
        @(negedge clk);
        n_chk++;
        if (!found || an !== 4'hF || seg !== 7'h7F || err !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_fault found=%b an=%b seg=%h err=%b expected 1111/7f/1", found, an, seg, err);
        end
        @(negedge clk);
        force_en = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2 * DIV; k++) begin
            @(negedge clk);
            e = exp_out();
            n_chk++;
            if ({an, seg, dp_n} !== e || err !== 1'b1) begin
                n_fail++;
                $display("FAIL sel_sticky t=%0d an=%b seg=%h err=%b expected an=%b seg=%h err=1", t, an, seg, err, e[11:8], e[7:1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        logic found = 1'b0;
        for (int k = 0; k < 3 * DIV && !found; k++) begin
            @(negedge clk);
            found = (t % DIV == DIV - 1);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (!found || {an, seg, dp_n, tick, err} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid found=%b an=%b seg=%h dp_n=%b tick=%b err=%b expected 1111/7f/1/0/0", found, an, seg, dp_n, tick, err);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3 * DIV; k++) begin
            @(negedge clk);
            e = exp_out();
            n_chk++;
            if ({an, seg, dp_n} !== e) begin
                n_fail++;
                $display("FAIL reset_mid_scan t=%0d an=%b seg=%h dp_n=%b expected an=%b seg=%h dp_n=%b", t, an, seg, dp_n, e[11:8], e[7:1], e[0]);
            end
            if (t == BLANK + 1) begin
                n_chk++;
                if (an !== 4'b1110 || seg !== 7'h40) begin
                    n_fail++;
                    $display("FAIL reset_mid_zero an=%b seg=%h expected 1110/40", an, seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_scan();
        test_lz();
        test_random();
        test_collision();
        test_sel_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
